// File: rtl/comb_2_decim.sv
// comb_2_decim: decimating second-order comb stage of the incremental-ADC CIC
// decimator. It takes one integrator sample every R clocks and applies
// (1 - z^-1)^2 at that decimated rate. A start pulse clears all history, so
// every conversion begins from zero state, in step with the integrator.
//
// Ports:
//   clk       rising-edge system clock
//   rst       synchronous active-high reset (overrides start)
//   start     conversion start: synchronous clear of counter and history
//   data_in   unsigned integrator output, full rate, WIDTH bits
//   data_out  comb result, unsigned modulo 2^WIDTH, updated on sample edges
//   valid_out one-cycle strobe, high in the cycle after each sample edge
//   settled   high once two or more decimated samples have been taken
module comb_2_decim #(
  parameter int WIDTH = 18,
  parameter int R     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             settled
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_z, d1_z;
  logic [WIDTH-1:0] d1, d2;
  logic [1:0]       nsamp;
  logic             smp;

  // Plain modular subtraction: the wrap is what makes the CIC correct when
  // the upstream integrator overflows, so no saturation or sign extension.
  always_comb begin
    d1  = data_in - x_z;
    d2  = d1 - d1_z;
    smp = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      // A sample edge coinciding with start is dropped along with its input.
      cnt       <= '0;
      x_z       <= '0;
      d1_z      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      settled   <= 1'b0;
      nsamp     <= 2'd0;
    end else if (smp) begin
      cnt       <= '0;
      x_z       <= data_in;
      d1_z      <= d1;
      data_out  <= d2;
      valid_out <= 1'b1;
      // nsamp saturates at 2; settled rises with the second sample.
      nsamp     <= (nsamp == 2'd2) ? 2'd2 : nsamp + 2'd1;
      settled   <= (nsamp != 2'd0);
    end else begin
      cnt       <= cnt + 1'b1;
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comb_2_decim.sv
// Directed bench for comb_2_decim: an R=4 instance driven from a per-edge
// vector table, plus a hand-written R=2 sequence on a second instance.
module tb_comb_2_decim;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst, start, rst2, start2;
  logic [W-1:0] din, din2;
  logic [W-1:0] dout, dout2;
  logic         vld, vld2, stl, stl2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comb_2_decim #(.WIDTH(W), .R(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .data_in(din),
    .data_out(dout), .valid_out(vld), .settled(stl)
  );

  comb_2_decim #(.WIDTH(W), .R(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .data_in(din2),
    .data_out(dout2), .valid_out(vld2), .settled(stl2)
  );

  // One record per clock edge: inputs applied before the edge, outputs
  // expected just after it.
  typedef struct {
    logic         rst;
    logic         start;
    logic [W-1:0] din;
    logic [W-1:0] ed;
    logic         ev;
    logic         es;
  } vec_t;

  vec_t         vq[$];
  logic [W-1:0] last_d;
  logic         last_s;

  task automatic push(input logic r, input logic s, input logic [W-1:0] d,
                      input logic [W-1:0] ed, input logic ev, input logic es);
    vec_t v;
    v.rst = r; v.start = s; v.din = d; v.ed = ed; v.ev = ev; v.es = es;
    vq.push_back(v);
  endtask

  // n edges of reset/clear: all outputs zero
  task automatic add_clr(input int n, input logic r, input logic s,
                         input logic [W-1:0] d);
    for (int i = 0; i < n; i++) push(r, s, d, '0, 1'b0, 1'b0);
    last_d = '0; last_s = 1'b0;
  endtask

  // One decimation period at R=4: three holding edges, then the sample edge.
  task automatic add_period(input logic [W-1:0] d, input logic [W-1:0] ed,
                            input logic es);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, d, last_d, 1'b0, last_s);
    push(1'b0, 1'b0, d, ed, 1'b1, es);
    last_d = ed; last_s = es;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0d required %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0;
    rst2 = 1'b1; start2 = 1'b0; din2 = '0;
    last_d = '0; last_s = 1'b0;

    // Reset held with nonzero input, then ramp
    add_clr(3, 1'b1, 1'b0, 18'd12345);
    add_period(18'd10,  18'd10, 1'b0);
    add_period(18'd30,  18'd10, 1'b1);
    add_period(18'd60,  18'd10, 1'b1);
    add_period(18'd100, 18'd10, 1'b1);
    // Wrap-around
    add_clr(1, 1'b1, 1'b0, '0);
    add_period(18'd262139, 18'd262139, 1'b0);
    add_period(18'd3,      18'd13,     1'b1);
    add_period(18'd11,     18'd0,      1'b1);
    // Start while cnt==3: sample suppressed, history cleared
    add_clr(1, 1'b1, 1'b0, '0);
    add_period(18'd10, 18'd10, 1'b0);
    add_period(18'd30, 18'd10, 1'b1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 18'd30, last_d, 1'b0, last_s);
    add_clr(1, 1'b0, 1'b1, 18'd999);
    add_period(18'd50, 18'd50,     1'b0);
    add_period(18'd70, 18'd262114, 1'b1);
    // rst and start together at the sample slot
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 18'd70, last_d, 1'b0, last_s);
    add_clr(1, 1'b1, 1'b1, 18'd777);
    add_period(18'd7, 18'd7, 1'b0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; start = vq[i].start; din = vq[i].din;
      @(posedge clk); #1;
      chk("data_out",  i, dout,       vq[i].ed);
      chk("valid_out", i, W'(vld),    W'(vq[i].ev));
      chk("settled",   i, W'(stl),    W'(vq[i].es));
    end

    // R=2: strobes on alternate edges, outputs 5, -5, 0
    @(negedge clk);
    rst = 1'b1; rst2 = 1'b1; din2 = 18'd5;
    @(posedge clk); #1;
    chk("r2 reset data", 0, dout2, '0);
    chk("r2 reset vld",  0, W'(vld2), '0);
    @(negedge clk);
    rst2 = 1'b0;
    begin
      logic [W-1:0] exp2 [3];
      logic         es2  [3];
      exp2[0] = 18'd5; exp2[1] = 18'd262139; exp2[2] = 18'd0;
      es2[0] = 1'b0;   es2[1] = 1'b1;        es2[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk("r2 idle vld", k, W'(vld2), '0);
        @(posedge clk); #1;
        chk("r2 strobe vld", k, W'(vld2), 18'd1);
        chk("r2 data",       k, dout2,    exp2[k]);
        chk("r2 settled",    k, W'(stl2), W'(es2[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comb_2_decim.md
Name: comb_2_decim

Overview:
- Decimating second-order comb (differentiator) stage. It is the back half of the incremental-ADC CIC decimator and sits directly after integrator_2.
- It downsamples the integrator output by R, then applies two cascaded first differences, (1 - z^-1)^2 at the decimated rate.
- It emits one result per R input clocks, flagged by a single-cycle valid strobe.
- A conversion-start input clears history, so each incremental conversion begins from zero state, matching the integrator reset.

Parameters:
- WIDTH, 18, data width of input and output. Must equal the integrator_2 output width. All arithmetic is modulo 2^WIDTH.
- R, 16, decimation ratio, >= 2. The counter width is clog2(R).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  conversion start: synchronous clear of counter and comb history
- data_in  input  WIDTH  unsigned integrator output, full rate
- data_out  output  WIDTH  comb result, unsigned, modulo 2^WIDTH
- valid_out  output  1  one-cycle strobe; data_out is new this cycle
- settled  output  1  high once >= 2 decimated samples have been taken since the last rst/start

Behaviour:
- Reset: one clock, synchronous, active-high, on port rst. At any clock edge with rst=1, the following are all cleared to 0 and hold while rst stays high:
  - cnt, x_z, d1_z, data_out
  - valid_out, settled, nsamp (2-bit saturating sample count)
- Priority: rst > start > normal operation.
- start=1 (rst=0): same clear as reset. The sample edge is suppressed even if cnt==R-1 that cycle; the input is discarded.
- Counter: cnt counts 0..R-1, incrementing every edge. The sample edge is the edge where cnt==R-1; cnt then wraps to 0.
  - After rst/start deassert, the first sample edge is the R-th subsequent edge.
- On a sample edge, compute modulo 2^WIDTH:
  - x = data_in
  - d1 = x - x_z
  - d2 = d1 - d1_z
- Registered on the same sample edge:
  - x_z <= x, d1_z <= d1, data_out <= d2
  - valid_out <= 1
  - nsamp <= min(nsamp+1, 2)
  - settled <= (nsamp+1 >= 2)
- Latency: data_in sampled at a sample edge appears on data_out in the cycle immediately following that edge.
- Non-sample edges: valid_out <= 0; data_out and history hold their values.
- valid_out is high exactly 1 cycle in every R.
- Wrap-around: subtraction is plain WIDTH-bit modular arithmetic with no saturation and no sign extension. This is required for CIC correctness with a wrapping integrator.
- settled stays high until the next rst/start. data_out is valid at every strobe; the first two outputs after start are the comb transient.
- R=2 must work: sample edges occur on alternate edges.

Test Plan (R=4, WIDTH=18 unless noted):
- Reset check:
  - Stimulus: hold rst=1 for 3 edges with data_in=12345.
  - Required: data_out=0, valid_out=0, settled=0 throughout.
  - Then release rst; the first valid_out must follow the 4th edge.
- Ramp:
  - Stimulus: after rst, data_in takes values 10, 30, 60, 100 at successive sample edges.
  - Required: data_out=10,10,10,10 on the four strobes.
  - Required: settled=0 after strobe 1, and =1 from strobe 2 on.
  - Required: valid_out is high exactly 1 cycle in every 4.
- Wrap:
  - Stimulus: data_in at sample edges = 262139, 3, 11.
  - Required: data_out=262139, 13, 0.
- Start mid-frame:
  - Stimulus: after two strobes (inputs 10, 30), assert start for 1 edge while cnt==3 with data_in=999.
  - Required: no strobe follows that edge, and settled=0.
  - Next stimulus: sample edges with inputs 50, 70.
  - Required: outputs 50, -30 mod 2^18 = 262114; settled=1 at the second strobe.
- Simultaneous rst and start:
  - Stimulus: both high.
  - Required: reset behaviour; no strobe.
- R=2 build:
  - Stimulus: data_in=5, 5, 5 at sample edges.
  - Required: outputs 5, 262139, 0; strobe every other cycle.
